id_ex_stage: RTL and testbench

- Decode stage of the 5-stage RV64 pipeline, plus the ID/EX pipeline register.
- Takes the IF/ID instruction and drives the register-file read addresses.
- Captures the register-file read data (with write-back bypass), immediate and control bits into the ID/EX register for the EX stage.
- Detects load-use hazards, stalls fetch and inserts bubbles; honours branch flushes from EX.

---
 rtl/rv_pkg.sv | 26 ++
 rtl/imm_gen.sv | 23 ++
 rtl/id_ex_stage.sv | 165 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV64 pipeline definitions: base opcodes, ALU-op encodings and the
// decoded control bundle that travels down the pipeline.
package rv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_R      = 2'b10;
   localparam logic [1:0] ALUOP_IMM    = 2'b11;

   typedef struct packed {
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I/S/B-type immediate of an instruction
// to XLEN bits; formats without an immediate produce zero.
module imm_gen
   import rv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      case (instr[6:0])
         OP_IMM, OP_LOAD: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
         OP_STORE:        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:       imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
         default:         imm = '0;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: decodes the IF/ID instruction,
// bypasses write-back data, detects load-use hazards and honours EX flushes.
module id_ex_stage
   import rv_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int NOP_ON_ILLEGAL = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_instr,
   output logic [4:0]      rf_rs1,
   output logic [4:0]      rf_rs2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            ex_flush,
   output logic            stall_if,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rdata1,
   output logic [XLEN-1:0] ex_rdata2,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic [1:0]      ex_alu_op,
   output logic            ex_alu_src,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_reg_write,
   output logic            ex_mem_to_reg,
   output logic            ex_branch,
   output logic            ex_illegal
);

   logic [6:0]      opcode;
   ctrl_t           dec_ctrl;
   logic            supported;
   logic            rs2_used;
   logic            hz;
   logic            drop_illegal;
   logic [XLEN-1:0] imm;
   ctrl_t           ex_ctrl_reg;

   logic [4:0]      rs_addr [2];
   logic [XLEN-1:0] rf_data [2];
   logic [XLEN-1:0] op_data [2];

   assign opcode  = if_instr[6:0];
   assign rf_rs1  = if_instr[19:15];
   assign rf_rs2  = if_instr[24:20];
   assign rs_addr[0] = rf_rs1;
   assign rs_addr[1] = rf_rs2;
   assign rf_data[0] = rf_rdata1;
   assign rf_data[1] = rf_rdata2;

   always_comb begin
      dec_ctrl  = '0;
      supported = 1'b1;
      rs2_used  = 1'b0;
      case (opcode)
         OP_R: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = ALUOP_R;
            rs2_used           = 1'b1;
         end
         OP_IMM: begin
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = ALUOP_IMM;
         end
         OP_LOAD: begin
            dec_ctrl.alu_src    = 1'b1;
            dec_ctrl.mem_read   = 1'b1;
            dec_ctrl.reg_write  = 1'b1;
            dec_ctrl.mem_to_reg = 1'b1;
            dec_ctrl.alu_op     = ALUOP_ADD;
         end
         OP_STORE: begin
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.mem_write = 1'b1;
            dec_ctrl.alu_op    = ALUOP_ADD;
            rs2_used           = 1'b1;
         end
         OP_BRANCH: begin
            dec_ctrl.branch = 1'b1;
            dec_ctrl.alu_op = ALUOP_BRANCH;
            rs2_used        = 1'b1;
         end
         default: supported = 1'b0;
      endcase
   end

   assign drop_illegal = !supported && (NOP_ON_ILLEGAL != 0);

   // x0 is hard zero and must win over a (bogus) write-back to x0.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
         always_comb begin
            if (rs_addr[gi] == 5'd0)
               op_data[gi] = '0;
            else if (wb_reg_write && (wb_rd == rs_addr[gi]))
               op_data[gi] = wb_data;
            else
               op_data[gi] = rf_data[gi];
         end
      end
   endgenerate

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (if_instr),
      .imm   (imm)
   );

   assign hz = ex_valid && ex_ctrl_reg.mem_read && (ex_rd != 5'd0) && if_valid &&
               ((ex_rd == rf_rs1) || ((ex_rd == rf_rs2) && rs2_used));

   assign stall_if = hz && !ex_flush && !reset;

   always_ff @(posedge clk) begin
      if (reset || ex_flush || hz || !if_valid) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rdata1   <= '0;
         ex_rdata2   <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct3   <= '0;
         ex_funct7b5 <= 1'b0;
         ex_ctrl_reg <= '0;
         ex_illegal  <= 1'b0;
      end else begin
         ex_valid    <= 1'b1;
         ex_pc       <= if_pc;
         ex_rdata1   <= op_data[0];
         ex_rdata2   <= op_data[1];
         ex_imm      <= imm;
         ex_rs1      <= rf_rs1;
         ex_rs2      <= rf_rs2;
         ex_rd       <= drop_illegal ? 5'd0 : if_instr[11:7];
         ex_funct3   <= if_instr[14:12];
         ex_funct7b5 <= if_instr[30];
         ex_ctrl_reg <= drop_illegal ? '0 : dec_ctrl;
         ex_illegal  <= !supported;
      end
   end

   assign ex_alu_op     = ex_ctrl_reg.alu_op;
   assign ex_alu_src    = ex_ctrl_reg.alu_src;
   assign ex_mem_read   = ex_ctrl_reg.mem_read;
   assign ex_mem_write  = ex_ctrl_reg.mem_write;
   assign ex_reg_write  = ex_ctrl_reg.reg_write;
   assign ex_mem_to_reg = ex_ctrl_reg.mem_to_reg;
   assign ex_branch     = ex_ctrl_reg.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: decode, bypass, load-use
// stall, flush priority, reset during stall and illegal-opcode handling.
module tb_id_ex_stage;

   localparam int XLEN = 64;

   localparam logic [31:0] I_ADD      = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_ADD_X0   = 32'h002001B3; // add  x3,x0,x2
   localparam logic [31:0] I_LD       = 32'h0080B283; // ld   x5,8(x1)
   localparam logic [31:0] I_ADD_USE  = 32'h00228333; // add  x6,x5,x2
   localparam logic [31:0] I_ADDI_M1  = 32'hFFF10313; // addi x6,x2,-1
   localparam logic [31:0] I_ADDI_5   = 32'h00510313; // addi x6,x2,5 (rs2 field = 5)
   localparam logic [31:0] I_SD       = 32'hFE20BC23; // sd   x2,-8(x1)
   localparam logic [31:0] I_BEQ      = 32'hFE2088E3; // beq  x1,x2,-16
   localparam logic [31:0] I_ILLEGAL  = 32'h0000007F;

   logic            clk = 1'b0;
   logic            reset;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;
   logic [4:0]      rf_rs1, rf_rs2;
   logic [XLEN-1:0] rf_rdata1, rf_rdata2;
   logic            wb_reg_write;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ex_flush;
   logic            stall_if;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
   logic [4:0]      ex_rs1, ex_rs2, ex_rd;
   logic [2:0]      ex_funct3;
   logic            ex_funct7b5;
   logic [1:0]      ex_alu_op;
   logic            ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
   logic            ex_mem_to_reg, ex_branch, ex_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .NOP_ON_ILLEGAL(1)) dut (
      .clk           (clk),
      .reset         (reset),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .rf_rs1        (rf_rs1),
      .rf_rs2        (rf_rs2),
      .rf_rdata1     (rf_rdata1),
      .rf_rdata2     (rf_rdata2),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .ex_flush      (ex_flush),
      .stall_if      (stall_if),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_rdata1     (ex_rdata1),
      .ex_rdata2     (ex_rdata2),
      .ex_imm        (ex_imm),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .ex_rd         (ex_rd),
      .ex_funct3     (ex_funct3),
      .ex_funct7b5   (ex_funct7b5),
      .ex_alu_op     (ex_alu_op),
      .ex_alu_src    (ex_alu_src),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_to_reg (ex_mem_to_reg),
      .ex_branch     (ex_branch),
      .ex_illegal    (ex_illegal)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] instr);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = if_pc + 64'd4;
   endtask

   initial begin
      reset = 1'b1; if_valid = 1'b0; if_pc = 64'h1000; if_instr = 32'h0;
      rf_rdata1 = 64'd1; rf_rdata2 = 64'd2;
      wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = '0; ex_flush = 1'b0;
      step(); step();
      check_val("rst_ex_valid",   64'(ex_valid), 64'd0);
      check_val("rst_ex_illegal", 64'(ex_illegal), 64'd0);
      check_val("rst_stall_if",   64'(stall_if), 64'd0);
      check_val("rst_ex_rdata1",  ex_rdata1, 64'd0);
      reset = 1'b0;

      // Basic R-type issue
      issue(I_ADD);
      #1;
      check_val("add_rf_rs1", 64'(rf_rs1), 64'd1);
      check_val("add_rf_rs2", 64'(rf_rs2), 64'd2);
      step();
      check_val("add_ex_valid",  64'(ex_valid), 64'd1);
      check_val("add_ex_rdata1", ex_rdata1, 64'd1);
      check_val("add_ex_rdata2", ex_rdata2, 64'd2);
      check_val("add_ex_rd",     64'(ex_rd), 64'd3);
      check_val("add_ex_alu_op", 64'(ex_alu_op), 64'd2);
      check_val("add_ex_reg_wr", 64'(ex_reg_write), 64'd1);
      check_val("add_ex_pc",     ex_pc, 64'h1004);

      // Load followed by dependent add: one stall, one bubble
      issue(I_LD);
      step();
      check_val("ld_mem_read",   64'(ex_mem_read), 64'd1);
      check_val("ld_mem_to_reg", 64'(ex_mem_to_reg), 64'd1);
      check_val("ld_imm",        ex_imm, 64'd8);
      check_val("ld_funct3",     64'(ex_funct3), 64'd3);
      issue(I_ADD_USE);
      #1;
      check_val("lu_stall_1", 64'(stall_if), 64'd1);
      step();
      check_val("lu_bubble_valid", 64'(ex_valid), 64'd0);
      check_val("lu_bubble_mrd",   64'(ex_mem_read), 64'd0);
      check_val("lu_stall_2",      64'(stall_if), 64'd0);
      step();
      check_val("lu_add_valid", 64'(ex_valid), 64'd1);
      check_val("lu_add_rs1",   64'(ex_rs1), 64'd5);
      check_val("lu_add_rd",    64'(ex_rd), 64'd6);

      // Load followed by independent addi (negative immediate)
      issue(I_LD);
      step();
      issue(I_ADDI_M1);
      #1;
      check_val("addi_m1_stall", 64'(stall_if), 64'd0);
      step();
      check_val("addi_m1_valid", 64'(ex_valid), 64'd1);
      check_val("addi_m1_imm",   ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check_val("addi_m1_op",    64'(ex_alu_op), 64'd3);
      check_val("addi_m1_src",   64'(ex_alu_src), 64'd1);

      // rs2 field matches the load rd but rs2 is unused by I-ALU
      issue(I_LD);
      step();
      issue(I_ADDI_5);
      #1;
      check_val("addi_rs2f_stall", 64'(stall_if), 64'd0);
      step();
      check_val("addi_rs2f_imm", ex_imm, 64'd5);

      // Write-back bypass and x0 handling
      issue(I_ADD);
      wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 64'hDEAD; rf_rdata1 = 64'd1;
      step();
      check_val("byp_rdata1", ex_rdata1, 64'hDEAD);
      check_val("byp_rdata2", ex_rdata2, 64'd2);
      issue(I_ADD_X0);
      wb_rd = 5'd0; rf_rdata1 = 64'h55;
      step();
      check_val("x0_rdata1", ex_rdata1, 64'd0);
      issue(I_ADD);
      wb_reg_write = 1'b0; wb_rd = 5'd1; rf_rdata1 = 64'd1;
      step();
      check_val("nobyp_rdata1", ex_rdata1, 64'd1);

      // Flush coincident with a load-use hazard
      issue(I_LD);
      step();
      issue(I_ADD_USE);
      ex_flush = 1'b1;
      #1;
      check_val("fl_stall", 64'(stall_if), 64'd0);
      step();
      ex_flush = 1'b0;
      check_val("fl_valid", 64'(ex_valid), 64'd0);
      check_val("fl_mrd",   64'(ex_mem_read), 64'd0);

      // Reset asserted during a stall
      issue(I_LD);
      step();
      issue(I_ADD_USE);
      #1;
      check_val("rs_stall_pre", 64'(stall_if), 64'd1);
      reset = 1'b1;
      #1;
      check_val("rs_stall_drop", 64'(stall_if), 64'd0);
      step();
      check_val("rs_valid", 64'(ex_valid), 64'd0);
      check_val("rs_mrd",   64'(ex_mem_read), 64'd0);
      reset = 1'b0;

      // Store immediate
      issue(I_SD);
      step();
      check_val("sd_imm",  ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      check_val("sd_mwr",  64'(ex_mem_write), 64'd1);
      check_val("sd_rwr",  64'(ex_reg_write), 64'd0);

      // Branch
      issue(I_BEQ);
      step();
      check_val("beq_imm",    ex_imm, 64'hFFFF_FFFF_FFFF_FFF0);
      check_val("beq_branch", 64'(ex_branch), 64'd1);
      check_val("beq_alu_op", 64'(ex_alu_op), 64'd1);

      // Unsupported opcode
      issue(I_ILLEGAL);
      step();
      check_val("ill_flag",  64'(ex_illegal), 64'd1);
      check_val("ill_valid", 64'(ex_valid), 64'd1);
      check_val("ill_ctrl",  64'({ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
                                  ex_mem_to_reg, ex_branch, ex_alu_op}), 64'd0);

      // Empty IF/ID slot
      if_valid = 1'b0;
      step();
      check_val("nv_valid",   64'(ex_valid), 64'd0);
      check_val("nv_illegal", 64'(ex_illegal), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
